// File: rtl/branch_predictor_bht_pkg.sv
// Shared types for the fetch-stage branch history table / target buffer.
// Counter encoding, table entry layout and the 2-bit saturating update.
package bp_pkg;

   localparam int BP_ENTRIES = 16;
   localparam int BP_ADDR_WIDTH = 32;
   localparam int BP_TAG_BITS = 8;
   localparam logic [1:0] BP_CTR_ALLOC = 2'b10;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bp_ctr_t;

   typedef struct packed {
      logic                     valid;
      logic [BP_TAG_BITS-1:0]   tag;
      logic [BP_ADDR_WIDTH-1:0] target;
      bp_ctr_t                  ctr;
   } bp_entry_t;

   function automatic bp_ctr_t ctr_next(bp_ctr_t ctr, logic taken);
      bp_ctr_t nxt;
      nxt = ctr;
      if (taken && ctr != ST) nxt = bp_ctr_t'(ctr + 2'd1);
      if (!taken && ctr != SNT) nxt = bp_ctr_t'(ctr - 2'd1);
      return nxt;
   endfunction

endpackage

// File: rtl/branch_predictor_bht.sv
// Direct-mapped BHT + BTB: combinational fetch lookup, decode-time training.
// Build with BP_STATS_EN to add saturating branch / mispredict counters.
module branch_predictor_bht
   import bp_pkg::*;
#(
   parameter int ENTRIES = bp_pkg::BP_ENTRIES,
   parameter int ADDR_WIDTH = bp_pkg::BP_ADDR_WIDTH,
   parameter int TAG_BITS = bp_pkg::BP_TAG_BITS,
   parameter logic [1:0] CTR_ALLOC = bp_pkg::BP_CTR_ALLOC
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [ADDR_WIDTH-1:0] i_fetch_pc,
   output logic                  o_pred_hit,
   output logic                  o_pred_taken,
   output logic [ADDR_WIDTH-1:0] o_pred_target,
   input  logic                  i_upd_valid,
   input  logic [ADDR_WIDTH-1:0] i_upd_pc,
   input  logic                  i_upd_taken,
   input  logic [ADDR_WIDTH-1:0] i_upd_target,
   input  logic                  i_upd_pred_taken,
   input  logic [ADDR_WIDTH-1:0] i_upd_pred_target,
   output logic                  o_mispredict,
   input  logic                  i_bp_clear
`ifdef BP_STATS_EN
   ,
   output logic [15:0]           o_stat_branches,
   output logic [15:0]           o_stat_mispred
`endif
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_LO = IDX_W + 2;

   logic                  valid_q [ENTRIES];
   logic [TAG_BITS-1:0]   tag_q   [ENTRIES];
   logic [ADDR_WIDTH-1:0] tgt_q   [ENTRIES];
   bp_ctr_t               ctr_q   [ENTRIES];

   logic [IDX_W-1:0]    fidx;
   logic [TAG_BITS-1:0] ftag;
   logic [IDX_W-1:0]    uidx;
   logic [TAG_BITS-1:0] utag;
   logic                uhit;
   logic                unused_ok;

   assign fidx = i_fetch_pc[IDX_W+1:2];
   assign ftag = i_fetch_pc[TAG_LO+TAG_BITS-1:TAG_LO];
   assign uidx = i_upd_pc[IDX_W+1:2];
   assign utag = i_upd_pc[TAG_LO+TAG_BITS-1:TAG_LO];
   assign unused_ok = ^{i_fetch_pc, i_upd_pc};

   // Lookup reads the registered table, so a same-cycle update is not seen.
   assign o_pred_hit = valid_q[fidx] && (tag_q[fidx] == ftag);
   assign o_pred_taken = o_pred_hit && ctr_q[fidx][1];
   assign o_pred_target = o_pred_taken ? tgt_q[fidx]
                                       : i_fetch_pc + ADDR_WIDTH'(4);

   assign uhit = valid_q[uidx] && (tag_q[uidx] == utag);

   assign o_mispredict = i_upd_valid &&
      ((i_upd_taken != i_upd_pred_taken) ||
       (i_upd_taken && (i_upd_target != i_upd_pred_target)));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            tag_q[i]   <= '0;
            tgt_q[i]   <= '0;
            ctr_q[i]   <= WNT;
         end
      end else if (i_bp_clear) begin
         for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
      end else if (i_upd_valid) begin
         if (uhit) begin
            ctr_q[uidx] <= ctr_next(ctr_q[uidx], i_upd_taken);
            if (i_upd_taken) tgt_q[uidx] <= i_upd_target;
         end else if (i_upd_taken) begin
            valid_q[uidx] <= 1'b1;
            tag_q[uidx]   <= utag;
            tgt_q[uidx]   <= i_upd_target;
            ctr_q[uidx]   <= bp_ctr_t'(CTR_ALLOC);
         end
      end
   end

`ifdef BP_STATS_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_stat_branches <= '0;
         o_stat_mispred  <= '0;
      end else if (i_bp_clear) begin
         o_stat_branches <= '0;
         o_stat_mispred  <= '0;
      end else if (i_upd_valid) begin
         if (o_stat_branches != 16'hFFFF)
            o_stat_branches <= o_stat_branches + 16'd1;
         if (o_mispredict && o_stat_mispred != 16'hFFFF)
            o_stat_mispred <= o_stat_mispred + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed bench for branch_predictor_bht with a queue of expected values.
// Stats checks run only when BP_STATS_EN is defined.
module tb_branch_predictor_bht;

   logic        clk;
   logic        rst_n;
   logic [31:0] fetch_pc;
   logic        pred_hit;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_pred_taken;
   logic [31:0] upd_pred_target;
   logic        mispredict;
   logic        bp_clear;
`ifdef BP_STATS_EN
   logic [15:0] stat_branches;
   logic [15:0] stat_mispred;
`endif

   branch_predictor_bht dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .i_fetch_pc(fetch_pc),
      .o_pred_hit(pred_hit),
      .o_pred_taken(pred_taken),
      .o_pred_target(pred_target),
      .i_upd_valid(upd_valid),
      .i_upd_pc(upd_pc),
      .i_upd_taken(upd_taken),
      .i_upd_target(upd_target),
      .i_upd_pred_taken(upd_pred_taken),
      .i_upd_pred_target(upd_pred_target),
      .o_mispredict(mispredict),
      .i_bp_clear(bp_clear)
`ifdef BP_STATS_EN
      ,
      .o_stat_branches(stat_branches),
      .o_stat_mispred(stat_mispred)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      int          sel;
      logic [31:0] val;
   } exp_t;

   exp_t q[$];
   int total = 0;
   int bad = 0;

   function automatic logic [31:0] obs_f(int sel);
      logic [31:0] o;
      o = 32'hDEAD_BEEF;
      case (sel)
         0: o = {31'd0, pred_hit};
         1: o = {31'd0, pred_taken};
         2: o = pred_target;
         3: o = {31'd0, mispredict};
`ifdef BP_STATS_EN
         4: o = {16'd0, stat_branches};
         5: o = {16'd0, stat_mispred};
`endif
         default: o = 32'hDEAD_BEEF;
      endcase
      return o;
   endfunction

   task automatic push(string n, int s, logic [31:0] v);
      exp_t e;
      e.name = n;
      e.sel = s;
      e.val = v;
      q.push_back(e);
   endtask

   task automatic check_all();
      #1;
      while (q.size() > 0) begin
         exp_t e;
         logic [31:0] o;
         e = q.pop_front();
         o = obs_f(e.sel);
         total++;
         assert (o === e.val) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", e.name, o, e.val);
         end
      end
   endtask

   task automatic look(string n, logic [31:0] pc, logic h, logic t,
                       logic [31:0] tg);
      @(negedge clk);
      fetch_pc = pc;
      push({n, "_hit"}, 0, {31'd0, h});
      push({n, "_taken"}, 1, {31'd0, t});
      push({n, "_target"}, 2, tg);
      check_all();
   endtask

   task automatic upd(string n, logic [31:0] pc, logic tk, logic [31:0] tg,
                      logic pt, logic [31:0] ptg, logic mp);
      @(negedge clk);
      upd_valid = 1'b1;
      upd_pc = pc;
      upd_taken = tk;
      upd_target = tg;
      upd_pred_taken = pt;
      upd_pred_target = ptg;
      push({n, "_mp"}, 3, {31'd0, mp});
      check_all();
      @(posedge clk);
      #1;
      upd_valid = 1'b0;
   endtask

   logic [8:0] walk_tk = 9'b000_1111_00;
   logic [8:0] walk_pr = 9'b000_0111_10;
   logic       prev;

   initial begin
      rst_n = 1'b0;
      fetch_pc = '0;
      upd_valid = 1'b0;
      upd_pc = '0;
      upd_taken = 1'b0;
      upd_target = '0;
      upd_pred_taken = 1'b0;
      upd_pred_target = '0;
      bp_clear = 1'b0;
      #12 rst_n = 1'b1;

      look("reset", 32'h40, 1'b0, 1'b0, 32'h44);
      @(negedge clk);
      upd_pred_taken = 1'b1;
      push("mp_idle", 3, 32'd0);
      check_all();
      upd_pred_taken = 1'b0;

      // allocate 0x40 while fetching it: lookup must still miss this cycle
      @(negedge clk);
      fetch_pc = 32'h40;
      upd_valid = 1'b1;
      upd_pc = 32'h40;
      upd_taken = 1'b1;
      upd_target = 32'h80;
      upd_pred_taken = 1'b0;
      upd_pred_target = 32'h44;
      push("alloc_mp", 3, 32'd1);
      push("same_cyc_hit", 0, 32'd0);
      check_all();
      @(posedge clk);
      #1 upd_valid = 1'b0;
      look("alloc", 32'h40, 1'b1, 1'b1, 32'h80);

      // counter walk from weak-taken through both saturation points
      prev = 1'b1;
      for (int i = 8; i >= 0; i--) begin
         upd("walk", 32'h40, walk_tk[i], 32'h80, prev,
             prev ? 32'h80 : 32'h44, walk_tk[i] != prev);
         look("walk", 32'h40, 1'b1, walk_pr[i],
              walk_pr[i] ? 32'h80 : 32'h44);
         prev = walk_pr[i];
      end

      // alias on the same index with a different tag
      look("alias_miss", 32'h80, 1'b0, 1'b0, 32'h84);
      upd("alias_alloc", 32'h80, 1'b1, 32'h100, 1'b0, 32'h84, 1'b1);
      look("alias_new", 32'h80, 1'b1, 1'b1, 32'h100);
      look("alias_old", 32'h40, 1'b0, 1'b0, 32'h44);
      upd("tgt_wrong", 32'h80, 1'b1, 32'h200, 1'b1, 32'h100, 1'b1);
      look("tgt_over", 32'h80, 1'b1, 1'b1, 32'h200);
      upd("pred_ok", 32'h80, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0);
      upd("nt_keep", 32'h80, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1);
      look("nt_keep", 32'h80, 1'b1, 1'b1, 32'h200);
      look("tag_alias", 32'h4080, 1'b1, 1'b1, 32'h200);
      look("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

      // clear wins over a simultaneous allocation
      @(negedge clk);
      bp_clear = 1'b1;
      upd_valid = 1'b1;
      upd_pc = 32'h10;
      upd_taken = 1'b1;
      upd_target = 32'h20;
      upd_pred_taken = 1'b0;
      @(posedge clk);
      #1;
      bp_clear = 1'b0;
      upd_valid = 1'b0;
      look("clr_upd", 32'h10, 1'b0, 1'b0, 32'h14);
      look("clr_old", 32'h80, 1'b0, 1'b0, 32'h84);

      // reset held across an update edge drops the write
      upd("pre_rst", 32'h40, 1'b1, 32'h80, 1'b0, 32'h44, 1'b1);
      look("pre_rst", 32'h40, 1'b1, 1'b1, 32'h80);
      @(negedge clk);
      upd_valid = 1'b1;
      upd_pc = 32'h8;
      upd_taken = 1'b1;
      upd_target = 32'h300;
      #2 rst_n = 1'b0;
      @(posedge clk);
      #1;
      upd_valid = 1'b0;
      rst_n = 1'b1;
      look("rst_a", 32'h40, 1'b0, 1'b0, 32'h44);
      look("rst_b", 32'h8, 1'b0, 1'b0, 32'hC);

`ifdef BP_STATS_EN
      look("st0", 32'h0, 1'b0, 1'b0, 32'h4);
      push("st0_br", 4, 32'd0);
      push("st0_mp", 5, 32'd0);
      check_all();
      upd("s1", 32'h40, 1'b1, 32'h80, 1'b0, 32'h44, 1'b1);
      upd("s2", 32'h40, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0);
      upd("s3", 32'h40, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0);
      upd("s4", 32'h40, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1);
      upd("s5", 32'h50, 1'b0, 32'h0, 1'b0, 32'h54, 1'b0);
      push("st5_br", 4, 32'd5);
      push("st5_mp", 5, 32'd2);
      check_all();
      @(negedge clk);
      upd_valid = 1'b1;
      upd_pc = 32'h60;
      upd_taken = 1'b1;
      upd_target = 32'h90;
      upd_pred_taken = 1'b0;
      upd_pred_target = 32'h64;
      repeat (70000) @(posedge clk);
      #1 upd_valid = 1'b0;
      push("sat_br", 4, 32'hFFFF);
      push("sat_mp", 5, 32'hFFFF);
      check_all();
      @(negedge clk);
      bp_clear = 1'b1;
      @(posedge clk);
      #1 bp_clear = 1'b0;
      push("clr_br", 4, 32'd0);
      push("clr_mp", 5, 32'd0);
      check_all();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
